param_sp_ram: RTL and testbench

Parametrised single-port synchronous RAM and the next generation of the team's basic single-port RAM. It adds byte-lane write enables, a selectable read-during-write mode, a one-cycle registered read with a valid strobe, and out-of-range address detection. After every reset it runs a hardware clear sequence that zeroes the whole array before it accepts traffic. It is used as a local scratch or buffer memory behind a simple request/ready master.

---
 rtl/param_sp_ram_if.sv | 28 ++
 rtl/param_sp_ram.sv | 136 +++++++++++++
 tb/tb_param_sp_ram.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/param_sp_ram_if.sv
// Request/response bus between a simple request/ready master and param_sp_ram.
// The master drives the request fields; the RAM returns data, strobes and ready.
interface param_sp_ram_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  ready;
  logic                  err;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, rvalid, ready, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, rvalid, ready, err
  );
endinterface

// File: rtl/param_sp_ram.sv
// Single-port synchronous RAM with byte-lane writes, selectable read-during-write,
// registered 1-cycle response, out-of-range detection and a post-reset clear pass.
module param_sp_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 48,
  parameter int unsigned RDW_MODE   = 0
) (
  input logic            clk,
  input logic            rst_n,
  param_sp_ram_if.slave  bus
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          WR_FIRST = (RDW_MODE != 0);

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  state_t                state;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready;
  logic                  accept;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      clr_idx;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  err_q;

  // ---------------------------------------------------------------------------
  // Clear / serve state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // The counter parks at DEPTH once the clear pass finishes; it never wraps.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      INIT: begin
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready = (state == IDLE);

  // ---------------------------------------------------------------------------
  // Access decode and byte-lane merge
  // ---------------------------------------------------------------------------
  assign accept   = ready && bus.req;
  assign in_range = ({1'b0, bus.addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign idx      = bus.addr[IDX_W-1:0];
  assign clr_idx  = cnt[IDX_W-1:0];
  assign old_word = mem[idx];

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      if (bus.be[i]) begin
        merged[8*i +: 8] = bus.wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: cleared word by word in INIT, written by accepted writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_idx] <= '0;
    end else if (accept && bus.we && in_range) begin
      mem[idx] <= merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= accept;
      err_q    <= accept && !in_range;
      if (accept) begin
        if (!in_range) begin
          rdata_q <= '0;
        end else if (bus.we && WR_FIRST) begin
          rdata_q <= merged;
        end else begin
          rdata_q <= old_word;
        end
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.ready  = ready;

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: drives one read-first and one write-first instance with
// identical traffic and checks both against a word-level memory model every cycle.
module tb_param_sp_ram;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    be = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_sp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  param_sp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  assign if0.req = req;   assign if1.req = req;
  assign if0.we = we;     assign if1.we = we;
  assign if0.addr = addr; assign if1.addr = addr;
  assign if0.wdata = wdata; assign if1.wdata = wdata;
  assign if0.be = be;     assign if1.be = be;

  param_sp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  param_sp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: a plain array plus the count of clear edges since reset.
  logic [DW-1:0] mm [DEPTH];
  int            edges = 0;
  logic          exp_ready = 1'b0, exp_rvalid = 1'b0, exp_err = 1'b0;
  logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
  logic [DW-1:0] m_old, m_new;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges = 0;
      exp_ready = 1'b0; exp_rvalid = 1'b0; exp_err = 1'b0;
      exp_rd0 = '0; exp_rd1 = '0;
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    end else begin
      if (exp_ready && req) begin
        exp_rvalid = 1'b1;
        if (int'(addr) >= DEPTH) begin
          exp_err = 1'b1; exp_rd0 = '0; exp_rd1 = '0;
        end else begin
          m_old = mm[addr];
          m_new = m_old;
          for (int l = 0; l < 2; l++) if (be[l]) m_new[8*l +: 8] = wdata[8*l +: 8];
          exp_err = 1'b0;
          exp_rd0 = m_old;
          exp_rd1 = we ? m_new : m_old;
          if (we) mm[addr] = m_new;
        end
      end else begin
        exp_rvalid = 1'b0; exp_err = 1'b0;
      end
      if (!exp_ready) begin
        edges++;
        if (edges == DEPTH) exp_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_ready0",  32'(if0.ready),  32'(exp_ready));
    chk("model_ready1",  32'(if1.ready),  32'(exp_ready));
    chk("model_rvalid0", 32'(if0.rvalid), 32'(exp_rvalid));
    chk("model_rvalid1", 32'(if1.rvalid), 32'(exp_rvalid));
    chk("model_err0",    32'(if0.err),    32'(exp_err));
    chk("model_err1",    32'(if1.err),    32'(exp_err));
    chk("model_rdata0",  32'(if0.rdata),  32'(exp_rd0));
    chk("model_rdata1",  32'(if1.rdata),  32'(exp_rd1));
  end

  // Holds a read request through INIT and counts edges until ready rises.
  task automatic wait_ready(input string tag);
    int n;
    logic saw_rv;
    n = 0; saw_rv = 1'b0;
    req = 1'b1; we = 1'b0; addr = '0; be = '0; wdata = '0;
    while (!(if0.ready && if1.ready) && n < 200) begin
      @(negedge clk);
      n++;
      saw_rv |= if0.rvalid | if1.rvalid;
    end
    chk({tag, "_ready_edges"}, 32'(n), 32'd48);
    chk({tag, "_no_rvalid_in_init"}, 32'(saw_rv), 32'd0);
  endtask

  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
  endtask

  task automatic resp(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                      input logic e_err);
    chk({name, "_rvalid0"}, 32'(if0.rvalid), 32'd1);
    chk({name, "_rvalid1"}, 32'(if1.rvalid), 32'd1);
    chk({name, "_err0"},    32'(if0.err),    32'(e_err));
    chk({name, "_err1"},    32'(if1.err),    32'(e_err));
    chk({name, "_rdata0"},  32'(if0.rdata),  32'(e0));
    chk({name, "_rdata1"},  32'(if1.rdata),  32'(e1));
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready",  32'(if0.ready),  32'd0);
    chk("reset_rvalid", 32'(if0.rvalid), 32'd0);
    chk("reset_err",    32'(if0.err),    32'd0);
    chk("reset_rdata",  32'(if0.rdata),  32'd0);
    #2 rst_n = 1'b1;
    wait_ready("init");

    for (int a = 0; a < DEPTH; a++) begin
      access(1'b0, AW'(a), '0, 2'b00);
      resp("clear_rd", 16'h0000, 16'h0000, 1'b0);
    end

    access(1'b1, 6'd5, 16'hF0E1, 2'b11); resp("wr_full",   16'h0000, 16'hF0E1, 1'b0);
    access(1'b0, 6'd5, '0, 2'b00);       resp("rd_full",   16'hF0E1, 16'hF0E1, 1'b0);
    access(1'b1, 6'd5, 16'hAA55, 2'b01); resp("wr_lane0",  16'hF0E1, 16'hF055, 1'b0);
    access(1'b0, 6'd5, '0, 2'b00);       resp("rd_lane0",  16'hF055, 16'hF055, 1'b0);
    access(1'b1, 6'd5, 16'h1200, 2'b00); resp("wr_be0",    16'hF055, 16'hF055, 1'b0);
    access(1'b0, 6'd5, '0, 2'b00);       resp("rd_be0",    16'hF055, 16'hF055, 1'b0);
    idle(); idle();
    chk("idle_rvalid", 32'(if0.rvalid), 32'd0);
    chk("idle_hold0",  32'(if0.rdata),  32'hF055);
    chk("idle_hold1",  32'(if1.rdata),  32'hF055);

    access(1'b1, 6'd2, 16'hD2D2, 2'b11); resp("preload",   16'h0000, 16'hD2D2, 1'b0);
    access(1'b1, 6'd2, 16'h1234, 2'b11); resp("rdw",       16'hD2D2, 16'h1234, 1'b0);
    access(1'b0, 6'd2, '0, 2'b00);       resp("rd_rdw",    16'h1234, 16'h1234, 1'b0);

    access(1'b0, 6'd50, '0, 2'b00);      resp("oor_rd",    16'h0000, 16'h0000, 1'b1);
    access(1'b1, 6'd63, 16'hFFFF, 2'b11); resp("oor_wr",   16'h0000, 16'h0000, 1'b1);
    access(1'b0, 6'd15, '0, 2'b00);      resp("alias15",   16'h0000, 16'h0000, 1'b0);
    access(1'b0, 6'd47, '0, 2'b00);      resp("alias47",   16'h0000, 16'h0000, 1'b0);
    access(1'b1, 6'd47, 16'hBEEF, 2'b10); resp("wr_top",   16'h0000, 16'hBE00, 1'b0);
    access(1'b0, 6'd47, '0, 2'b00);      resp("rd_top",    16'hBE00, 16'hBE00, 1'b0);

    access(1'b0, 6'd5, '0, 2'b00);       resp("stream_a",  16'hF055, 16'hF055, 1'b0);
    access(1'b0, 6'd2, '0, 2'b00);       resp("stream_b",  16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rvalid0", 32'(if0.rvalid), 32'd0);
    chk("midrst_rvalid1", 32'(if1.rvalid), 32'd0);
    chk("midrst_ready0",  32'(if0.ready),  32'd0);
    chk("midrst_ready1",  32'(if1.ready),  32'd0);
    chk("midrst_rdata0",  32'(if0.rdata),  32'd0);
    req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_ready("rerun");
    access(1'b0, 6'd5, '0, 2'b00);       resp("post_rst5", 16'h0000, 16'h0000, 1'b0);
    access(1'b0, 6'd2, '0, 2'b00);       resp("post_rst2", 16'h0000, 16'h0000, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
